mtm_alu_sin_deserializer: RTL and testbench
===========================================

Name: mtm_alu_sin_deserializer

Overview:
Receive side of the mtm_Alu command link. Samples the serial `sin` stream one bit per clock and assembles a 9-byte command frame: 8 DATA bytes (B then A, MSB byte first) plus 1 CTL byte. Checks the CTL byte's CRC4 and opcode. Presents B, A, op and error flags to the ALU core with a one-cycle valid strobe.

Parameters:
- DATA_BYTES, 8: number of DATA bytes per frame; the protocol fixes this at 8, and the parameter exists only for the bench.
- CRC_CHECK_EN, 1: when 0, the CRC mismatch check is disabled and err_flags[1] is never set.

Ports:
- clk  input  1  system clock; sin is sampled on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sin  input  1  serial command input; idles at 1.
- b_data  output  32  operand B of the last completed frame.
- a_data  output  32  operand A of the last completed frame.
- op  output  3  opcode field from the CTL byte.
- err_flags  output  3  {ERR_DATA, ERR_CRC, ERR_OP}; at most one bit is set.
- frame_valid  output  1  one-cycle strobe; the other outputs are valid while it is high.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; byte FSM to IDLE; byte counter 0; shift registers cleared.
- Byte format: 11 bits, one per clock: start 0, type bit (0=DATA, 1=CTL), 8 payload bits MSB first, stop 1.
- Byte FSM states:
  - IDLE: on sampling sin=0, go to TYPE.
  - TYPE: latch the type bit, go to PAYLOAD.
  - PAYLOAD: 8 cycles, shift payload bits in.
  - STOP: sample the stop bit, go to IDLE.
- Back-to-back bytes: a start bit in the cycle right after STOP is accepted; no idle gap is required.
- Stop bit = 0: the byte is discarded; the frame ends with ERR_DATA; the byte counter returns to 0.
- Frame handling, evaluated at the STOP sample (cnt = byte counter):
  - DATA byte, cnt<8: store payload at {B,A} byte position cnt; cnt++.
  - DATA byte, cnt==8: report ERR_DATA; cnt=0.
  - CTL byte, cnt<8: report ERR_DATA; cnt=0.
  - CTL byte, cnt==8: payload = {1'b0, op[2:0], crc[3:0]}; run the checks below; cnt=0.
- CRC4: polynomial x^4+x+1, initial remainder 0, computed over the 72-bit vector {B, A, 1'b1, op, 4'b0000}, MSB first. A mismatch gives ERR_CRC.
- Valid ops: 000 AND, 001 OR, 100 ADD, 101 SUB. Any other op gives ERR_OP.
- Error priority: ERR_DATA > ERR_CRC > ERR_OP.
- Reporting:
  - frame_valid goes high for exactly 1 cycle, starting at the edge after the final STOP sample (latency 1 clock).
  - On error, b_data/a_data/op are still driven with the captured values, but the core ignores them.
  - Outputs hold their values until the next report.
- Frames that start mid-frame after an error are simply re-synchronised on the next start bit. No timeout.
- rst_n asserted mid-byte or mid-frame: the partial frame is dropped with no frame_valid.

Decomposition:
- mtm_Alu_pkg gets:
  - op_t (AND/OR/ADD/SUB)
  - byte_type_t (DATA/CTL/ERR)
  - localparams ERR_DATA=3'b100, ERR_CRC=3'b010, ERR_OP=3'b001
  - function crc4_generate(B, A, op), shared with the bench
- Sub-module mtm_alu_byte_rx: bit-level FSM. Outputs byte_done pulse, byte_type, byte_data[7:0], stop_err.
- Top level: frame counter, operand shift-in, CRC/op checks, output registers.

Test Plan:
- Reset then idle: sin=1 for 100 cycles -> all outputs 0, frame_valid never asserted.
- Good frame: B=32'h0000_0005, A=32'h0000_0003, op=ADD, correct CRC -> 1 cycle after the 9th stop bit: frame_valid=1, b_data=5, a_data=3, op=3'b100, err_flags=000.
- Back-to-back good frames, no gap between them: AND of FFFF0000/0F0F0F0F, then SUB of 10/1 -> two strobes 99 cycles apart, both with err_flags=000.
- CTL byte after only 7 DATA bytes -> err_flags=100. A following good frame is then received cleanly.
- 9 DATA bytes -> err_flags=100.
- Wrong CRC (correct CRC + 1) -> err_flags=010.
- CRC_CHECK_EN=0 variant: wrong CRC -> err_flags=000.
- op=3'b010 with correct CRC -> err_flags=001.
- rst_n pulsed low during the 5th byte -> no strobe. The next full good frame is decoded correctly.

Source files
------------

// File: rtl/mtm_Alu_pkg.sv
// Shared types, error codes and CRC4 helper for the mtm_Alu command link.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mtm_Alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_t;

    typedef enum logic [1:0] {
        BT_DATA = 2'd0,
        BT_CTL  = 2'd1,
        BT_ERR  = 2'd2
    } byte_type_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_TYPE,
        RX_PAYLOAD,
        RX_STOP
    } rx_state_t;

    localparam logic [2:0] ERR_DATA  = 3'b100;
    localparam logic [2:0] ERR_CRC   = 3'b010;
    localparam logic [2:0] ERR_OP    = 3'b001;

    // Low four coefficients of x^4+x+1; the x^4 term is implied.
    localparam logic [3:0] CRC4_POLY = 4'b0011;

    // Remainder of {B, A, 1, op, 0000} divided by x^4+x+1, MSB first.
    // Each step multiplies the running remainder by x, brings in the next
    // bit and reduces whenever the x^4 term would be set.
    function automatic logic [3:0] crc4_generate(input logic [31:0] b,
                                                 input logic [31:0] a,
                                                 input logic [2:0]  op);
        logic [71:0] v;
        logic [3:0]  rem;
        v   = {b, a, 1'b1, op, 4'b0000};
        rem = 4'b0000;
        for (int i = 71; i >= 0; i--) begin
            rem = {rem[2:0], v[i]} ^ (rem[3] ? CRC4_POLY : 4'b0000);
        end
        return rem;
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mtm_alu_byte_rx.sv
// Bit-level receiver: start, type, 8 payload bits MSB first, stop (11 clocks/byte).
// Latency: o_byte_done is asserted combinationally during the stop-bit cycle.
// Backpressure: none; the serial line cannot be stalled, bytes are reported as they end.
// Ports: clk, rst_n (async active-low), i_sin serial in; o_byte_done strobe,
//        o_byte_type (DATA/CTL/ERR), o_byte_data payload, o_stop_err (stop bit was 0).
module mtm_alu_byte_rx
    import mtm_Alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sin,
    output logic             o_byte_done,
    output byte_type_t       o_byte_type,
    output logic [7:0]       o_byte_data,
    output logic             o_stop_err
);

    rx_state_t  r_state;
    rx_state_t  w_state_nxt;
    logic       r_type;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_type    <= 1'b0;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                RX_TYPE: begin
                    r_type    <= i_sin;
                    r_bit_cnt <= 3'd0;
                end
                RX_PAYLOAD: begin
                    r_shift   <= {r_shift[6:0], i_sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_byte_done = 1'b0;
        o_stop_err  = 1'b0;
        o_byte_type = r_type ? BT_CTL : BT_DATA;
        o_byte_data = r_shift;
        case (r_state)
            RX_IDLE:    if (!i_sin) w_state_nxt = RX_TYPE;
            RX_TYPE:    w_state_nxt = RX_PAYLOAD;
            RX_PAYLOAD: if (r_bit_cnt == 3'd7) w_state_nxt = RX_STOP;
            RX_STOP: begin
                // Always back to IDLE so a start bit in the very next cycle is caught.
                w_state_nxt = RX_IDLE;
                o_byte_done = 1'b1;
                o_stop_err  = ~i_sin;
                if (!i_sin) o_byte_type = BT_ERR;
            end
            default:    w_state_nxt = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/mtm_alu_sin_deserializer.sv
// Assembles 8 DATA + 1 CTL byte frames from sin, checks CRC4/opcode, reports to the ALU core.
// Latency: frame_valid rises one clock after the final stop bit is on sin.
// Backpressure: none; each report is a one-cycle strobe and outputs hold until the next one.
// Ports: clk, rst_n (async active-low), sin (idles 1); b_data, a_data, op,
//        err_flags {ERR_DATA, ERR_CRC, ERR_OP}, frame_valid.
module mtm_alu_sin_deserializer
    import mtm_Alu_pkg::*;
#(
    parameter int DATA_BYTES   = 8,
    parameter bit CRC_CHECK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [31:0] b_data,
    output logic [31:0] a_data,
    output logic [2:0]  op,
    output logic [2:0]  err_flags,
    output logic        frame_valid
);

    localparam int FRAME_W = DATA_BYTES * 8;
    localparam int CNT_W   = $clog2(DATA_BYTES + 1);

    logic               w_byte_done;
    byte_type_t         w_byte_type;
    logic [7:0]         w_byte_data;
    logic               w_stop_err;

    logic [FRAME_W-1:0] r_data;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_full;
    logic [2:0]         w_ctl_op;
    logic [3:0]         w_ctl_crc;
    logic [3:0]         w_crc_exp;
    logic               w_report;
    logic [2:0]         w_err;
    logic               w_store;
    logic               w_cnt_clr;
    logic               w_op_load;

    mtm_alu_byte_rx u_byte_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sin       (sin),
        .o_byte_done (w_byte_done),
        .o_byte_type (w_byte_type),
        .o_byte_data (w_byte_data),
        .o_stop_err  (w_stop_err)
    );

    assign w_full    = (r_cnt == CNT_W'(DATA_BYTES));
    assign w_ctl_op  = w_byte_data[6:4];
    assign w_ctl_crc = w_byte_data[3:0];
    assign w_crc_exp = crc4_generate(r_data[FRAME_W-1 -: 32], r_data[31:0], w_ctl_op);

    always_comb begin
        w_report  = 1'b0;
        w_err     = 3'b000;
        w_store   = 1'b0;
        w_cnt_clr = 1'b0;
        w_op_load = 1'b0;
        if (w_byte_done) begin
            if (w_stop_err) begin
                // Broken byte framing: drop the byte and abort the frame.
                w_report  = 1'b1;
                w_err     = ERR_DATA;
                w_cnt_clr = 1'b1;
            end else begin
                case (w_byte_type)
                    BT_DATA: begin
                        if (w_full) begin
                            w_report  = 1'b1;
                            w_err     = ERR_DATA;
                            w_cnt_clr = 1'b1;
                        end else begin
                            w_store = 1'b1;
                        end
                    end
                    BT_CTL: begin
                        w_report  = 1'b1;
                        w_cnt_clr = 1'b1;
                        w_op_load = 1'b1;
                        if (!w_full)
                            w_err = ERR_DATA;
                        else if (CRC_CHECK_EN && (w_ctl_crc != w_crc_exp))
                            w_err = ERR_CRC;
                        else if (!op_is_valid(w_ctl_op))
                            w_err = ERR_OP;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_cnt       <= '0;
            b_data      <= 32'h0;
            a_data      <= 32'h0;
            op          <= 3'b000;
            err_flags   <= 3'b000;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= w_report;
            // Bytes arrive MSB byte first, so shifting left places byte n at
            // {B,A} position n once the frame is complete.
            if (w_store) begin
                r_data <= {r_data[FRAME_W-9:0], w_byte_data};
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_cnt_clr) r_cnt <= '0;
            if (w_report) begin
                b_data    <= r_data[FRAME_W-1 -: 32];
                a_data    <= r_data[31:0];
                err_flags <= w_err;
            end
            if (w_op_load) op <= w_ctl_op;
        end
    end

endmodule

// File: tb/tb_mtm_alu_sin_deserializer.sv
module tb_mtm_alu_sin_deserializer;
    import mtm_Alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic [31:0] b_data, a_data, nb_data, na_data;
    logic [2:0]  op, err, nop, nerr;
    logic        fv, nfv;

    mtm_alu_sin_deserializer dut (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .b_data(b_data), .a_data(a_data), .op(op),
        .err_flags(err), .frame_valid(fv)
    );

    mtm_alu_sin_deserializer #(.CRC_CHECK_EN(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n), .sin(sin),
        .b_data(nb_data), .a_data(na_data), .op(nop),
        .err_flags(nerr), .frame_valid(nfv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] b, a;
        logic [2:0]  op, err;
        int          cyc;
    } rpt_t;

    typedef struct {
        logic [31:0] b, a;
        logic [2:0]  op, err, err_nc;
        bit          chk;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] b, a;
        logic [2:0]  op;
        logic [3:0]  crc_add;
        int          n_data;
        bit          ctl;
        int          gap;
        logic [2:0]  err, err_nc;
    } vec_t;

    rpt_t act_q[$];
    rpt_t actn_q[$];
    exp_t exp_q[$];
    int   got_cyc[$];

    int n_checks = 0;
    int n_err    = 0;

    always @(negedge clk) begin
        rpt_t r;
        if (fv === 1'b1) begin
            r.b = b_data; r.a = a_data; r.op = op; r.err = err; r.cyc = cyc;
            act_q.push_back(r);
        end
        if (nfv === 1'b1) begin
            r.b = nb_data; r.a = na_data; r.op = nop; r.err = nerr; r.cyc = cyc;
            actn_q.push_back(r);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference CRC by plain polynomial long division of the 72-bit vector.
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
        logic [71:0] v;
        v = {b, a, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        return v[3:0];
    endfunction

    function automatic logic [2:0] exp_err(input int n_data, input bit ctl, input logic [2:0] o,
                                           input logic [3:0] crc_add, input bit crc_en);
        if (!ctl || n_data != 8)                      return 3'b100;
        if (crc_en && crc_add != 4'd0)                return 3'b010;
        if (!(o inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
        return 3'b000;
    endfunction

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input bit is_ctl, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(is_ctl);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input vec_t v);
        logic [63:0] ba;
        logic [7:0]  d;
        logic [3:0]  crc;
        exp_t        e;
        ba = {v.b, v.a};
        for (int i = 0; i < v.n_data; i++) begin
            d = (i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom);
            send_byte(1'b0, d, 1'b1);
            if (i == 8) begin
                e = '{b: v.b, a: v.a, op: v.op, err: v.err, err_nc: v.err_nc, chk: 1'b0, cyc: cyc};
                exp_q.push_back(e);
            end
        end
        if (v.ctl) begin
            crc = ref_crc(v.b, v.a, v.op) + v.crc_add;
            send_byte(1'b1, {1'b0, v.op, crc}, 1'b1);
            e = '{b: v.b, a: v.a, op: v.op, err: v.err, err_nc: v.err_nc,
                  chk: (v.n_data == 8), cyc: cyc};
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        rpt_t r;
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("strobe_present", act_q.size() != 0, 1'b1);
            if (act_q.size() != 0) begin
                r = act_q.pop_front();
                got_cyc.push_back(r.cyc);
                check("strobe_cycle", r.cyc, e.cyc);
                check("err_flags", r.err, e.err);
                if (e.chk) begin
                    check("b_data", r.b, e.b);
                    check("a_data", r.a, e.a);
                    check("op", r.op, e.op);
                end
            end
            check("strobe_present_nc", actn_q.size() != 0, 1'b1);
            if (actn_q.size() != 0) begin
                r = actn_q.pop_front();
                check("strobe_cycle_nc", r.cyc, e.cyc);
                check("err_flags_nc", r.err, e.err_nc);
                if (e.chk) begin
                    check("b_data_nc", r.b, e.b);
                    check("a_data_nc", r.a, e.a);
                    check("op_nc", r.op, e.op);
                end
            end
        end
        check("extra_strobes", act_q.size(), 0);
        check("extra_strobes_nc", actn_q.size(), 0);
        act_q.delete();
        actn_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_b"},   b_data, 0);
        check({tag, "_a"},   a_data, 0);
        check({tag, "_op"},  op, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_fv"},  fv, 0);
        check({tag, "_nc"},  {nb_data, na_data} | 64'(nop) | 64'(nerr) | 64'(nfv), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        exp_t e;
        int   pick;

        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 3'b100, 4'd0, 8, 1'b1, 3, 3'b000, 3'b000};
        tbl[1] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'b000, 4'd0, 8, 1'b1, 0, 3'b000, 3'b000};
        tbl[2] = '{32'h0000_0010, 32'h0000_0001, 3'b101, 4'd0, 8, 1'b1, 4, 3'b000, 3'b000};
        tbl[3] = '{32'hDEAD_BEEF, 32'h1234_5678, 3'b100, 4'd0, 7, 1'b1, 2, 3'b100, 3'b100};
        tbl[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 4'd0, 8, 1'b1, 2, 3'b000, 3'b000};
        tbl[5] = '{32'hCAFE_F00D, 32'h0BAD_CAFE, 3'b000, 4'd0, 9, 1'b0, 2, 3'b100, 3'b100};
        tbl[6] = '{32'h0000_0005, 32'h0000_0003, 3'b100, 4'd1, 8, 1'b1, 2, 3'b010, 3'b000};
        tbl[7] = '{32'h0000_00AA, 32'h0000_0055, 3'b010, 4'd0, 8, 1'b1, 2, 3'b001, 3'b001};
        tbl[8] = '{32'h8000_0001, 32'h7FFF_FFFE, 3'b111, 4'd3, 8, 1'b1, 2, 3'b010, 3'b001};

        sin   = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(100);
        check_outputs_zero("idle");
        drain();

        for (int i = 0; i < 9; i++) begin
            if (i == 1) got_cyc.delete();
            send_frame(tbl[i]);
            if (tbl[i].gap != 0) begin
                idle(tbl[i].gap);
                drain();
            end
            if (i == 2)
                check("b2b_spacing", (got_cyc.size() >= 2) ? got_cyc[1] - got_cyc[0] : -1, 99);
        end

        // Stop bit low on the 4th byte: frame aborted with ERR_DATA, then recovery.
        send_byte(1'b0, 8'h11, 1'b1);
        send_byte(1'b0, 8'h22, 1'b1);
        send_byte(1'b0, 8'h33, 1'b1);
        send_byte(1'b0, 8'hA5, 1'b0);
        e = '{b: 32'h0, a: 32'h0, op: 3'b000, err: 3'b100, err_nc: 3'b100, chk: 1'b0, cyc: cyc};
        exp_q.push_back(e);
        idle(2);
        drain();
        send_frame(tbl[0]);
        drain();

        // Reset in the middle of the 5th byte: no strobe, clean decode afterwards.
        v = tbl[4];
        for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(i + 1), 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        idle(2);
        check_outputs_zero("mid_reset");
        rst_n = 1'b1;
        idle(2);
        drain();
        send_frame(v);
        drain();

        // Randomised frames checked against the rule-based expectation.
        for (int k = 0; k < 16; k++) begin
            v.b   = $urandom;
            v.a   = $urandom;
            v.op  = 3'($urandom_range(0, 7));
            pick  = $urandom_range(0, 9);
            v.n_data  = (pick == 0) ? 7 : (pick == 1) ? 9 : 8;
            v.ctl     = (v.n_data != 9);
            v.crc_add = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            v.gap     = $urandom_range(0, 2);
            v.err     = exp_err(v.n_data, v.ctl, v.op, v.crc_add, 1'b1);
            v.err_nc  = exp_err(v.n_data, v.ctl, v.op, v.crc_add, 1'b0);
            check("crc_fn", crc4_generate(v.b, v.a, v.op), ref_crc(v.b, v.a, v.op));
            send_frame(v);
            if (v.gap != 0) begin
                idle(v.gap);
                drain();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
